// File: rtl/wasca_nios2_gen2_0_cpu_ociram_arbiter.sv
// Two-port arbiter in front of the single-port on-chip debug RAM.
// Per-cycle grant, optional port-A lock, fixed 2-cycle read return.
module wasca_nios2_gen2_0_cpu_ociram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int BE_W       = 4,
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_TO    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  input  logic              a_lock,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_reset_req,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [7:0] IDLE_LAST = 8'(LOCK_TO - 1);

  logic              req_a;
  logic              req_b;
  logic              can_issue;
  logic              b_turn;
  logic              grant_a;
  logic              grant_b;
  logic              last_a;
  logic              lock_a;
  logic [7:0]        idle_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] data_q;
  logic              s1_valid;
  logic              s1_b;

  assign req_a     = a_read | a_write;
  assign req_b     = b_read | b_write;
  assign can_issue = reset_n & ~reset_req;

  // B takes a conflict only in round-robin mode after A held the last grant
  assign b_turn  = (FIXED_PRIO == 0) && last_a;
  assign grant_a = can_issue & req_a & (lock_a | ~req_b | ~b_turn);
  assign grant_b = can_issue & req_b & ~lock_a & (~req_a | b_turn);

  assign a_waitrequest = req_a & ~grant_a;
  assign b_waitrequest = req_b & ~grant_b;
  assign ram_reset_req = reset_req;

  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_data       = data_q;
    ram_wren       = 1'b0;
    unique case (1'b1)
      grant_a: begin
        ram_address    = a_address;
        ram_byteenable = a_byteenable;
        ram_data       = a_writedata;
        ram_wren       = a_write;
      end
      grant_b: begin
        ram_address    = b_address;
        ram_byteenable = b_byteenable;
        ram_data       = b_writedata;
        ram_wren       = b_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
      last_a <= 1'b0;
    end else if (grant_a | grant_b) begin
      addr_q <= ram_address;
      be_q   <= ram_byteenable;
      data_q <= ram_data;
      last_a <= grant_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_a   <= 1'b0;
      idle_cnt <= '0;
    end else if (grant_a) begin
      lock_a   <= a_lock;
      idle_cnt <= '0;
    end else if (req_a) begin
      idle_cnt <= '0;
    end else if (lock_a) begin
      if (idle_cnt == IDLE_LAST) begin
        lock_a   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

  // A read-write pair counts as a write, so it never enters the pipe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid        <= 1'b0;
      s1_b            <= 1'b0;
      a_readdatavalid <= 1'b0;
      b_readdatavalid <= 1'b0;
      a_readdata      <= '0;
      b_readdata      <= '0;
    end else begin
      s1_valid        <= (grant_a & ~a_write) | (grant_b & ~b_write);
      s1_b            <= grant_b;
      a_readdatavalid <= s1_valid & ~s1_b;
      b_readdatavalid <= s1_valid & s1_b;
      if (s1_valid & ~s1_b) a_readdata <= ram_q;
      if (s1_valid & s1_b)  b_readdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_wasca_nios2_gen2_0_cpu_ociram_arbiter.sv
// Directed bench: stimulus pushes expected reads into per-port queues,
// a negedge monitor pops and checks data and 2-cycle latency.
module tb_wasca_nios2_gen2_0_cpu_ociram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reset_req;
  logic [7:0]  a_address, b_address;
  logic [3:0]  a_byteenable, b_byteenable;
  logic        a_read, a_write, b_read, b_write, a_lock;
  logic [31:0] a_writedata, b_writedata;
  logic        a_waitrequest, b_waitrequest;
  logic [31:0] a_readdata, b_readdata;
  logic        a_readdatavalid, b_readdatavalid;
  logic [7:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        ram_reset_req;
  logic [31:0] ram_q;

  always #5 clk = ~clk;

  wasca_nios2_gen2_0_cpu_ociram_arbiter #(
    .ADDR_W(8), .DATA_W(32), .BE_W(4), .FIXED_PRIO(0), .LOCK_TO(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
    .a_address(a_address), .a_byteenable(a_byteenable),
    .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_lock(a_lock), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable),
    .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_reset_req(ram_reset_req), .ram_q(ram_q)
  );

  // RAM with registered address; reset_req freezes the clock enable
  logic [31:0] mem [256];
  logic [7:0]  ram_aq = '0;
  always @(posedge clk) begin
    if (!ram_reset_req) begin
      ram_aq <= ram_address;
      if (ram_wren)
        for (int i = 0; i < 4; i++)
          if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_data[8*i +: 8];
    end
  end
  assign ram_q = mem[ram_aq];

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(logic [31:0] d);
    qa.push_back('{d, cyc + 2});
  endtask

  task automatic push_b(logic [31:0] d);
    qb.push_back('{d, cyc + 2});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_readdatavalid) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_rdv: got unexpected pulse data %h, want none", a_readdata);
      end else begin
        e = qa.pop_front();
        check("a_rdata", a_readdata, e.data);
        check("a_latency", cyc, e.due);
      end
    end
    if (b_readdatavalid) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_rdv: got unexpected pulse data %h, want none", b_readdata);
      end else begin
        e = qb.pop_front();
        check("b_rdata", b_readdata, e.data);
        check("b_latency", cyc, e.due);
      end
    end
  end

  task automatic idle();
    a_read = 0; a_write = 0; a_lock = 0;
    b_read = 0; b_write = 0;
    a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_address = '0; b_byteenable = '0; b_writedata = '0;
  endtask

  task automatic a_op(bit wr, logic [7:0] ad, logic [31:0] d, logic [3:0] be);
    a_read = ~wr; a_write = wr;
    a_address = ad; a_writedata = d; a_byteenable = be;
  endtask

  task automatic b_op(bit wr, logic [7:0] ad, logic [31:0] d, logic [3:0] be);
    b_read = ~wr; b_write = wr;
    b_address = ad; b_writedata = d; b_byteenable = be;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string t);
    check({t, "_a_wait"}, a_waitrequest, 0);
    check({t, "_b_wait"}, b_waitrequest, 0);
    check({t, "_a_rdv"}, a_readdatavalid, 0);
    check({t, "_b_rdv"}, b_readdatavalid, 0);
    check({t, "_a_rd"}, a_readdata, 0);
    check({t, "_b_rd"}, b_readdata, 0);
    check({t, "_addr"}, ram_address, 0);
    check({t, "_be"}, ram_byteenable, 0);
    check({t, "_data"}, ram_data, 0);
    check({t, "_wren"}, ram_wren, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset_n = 0;
    reset_req = 0;
    next(); next();
    sample(); chk_zero("rst");
    reset_n = 1;
    next();

    // write then read same address back to back
    a_op(1, 8'h10, 32'hDEADBEEF, 4'hF);
    sample();
    check("t1_wr_wait", a_waitrequest, 0);
    check("t1_wren", ram_wren, 1);
    check("t1_addr", ram_address, 32'h10);
    check("t1_data", ram_data, 32'hDEADBEEF);
    next();
    a_op(0, 8'h10, 0, 4'hF);
    sample();
    check("t1_rd_wait", a_waitrequest, 0);
    check("t1_rd_wren", ram_wren, 0);
    push_a(32'hDEADBEEF);
    next(); idle();
    repeat (3) next();

    // partial byte-lane write
    a_op(1, 8'h20, 32'hAAAAAAAA, 4'hF);
    sample(); check("t3_w1_wait", a_waitrequest, 0);
    next();
    a_op(1, 8'h20, 32'h00005678, 4'h3);
    sample(); check("t3_be", ram_byteenable, 4'h3);
    next();
    a_op(1, 8'h01, 32'h11111111, 4'hF);
    next();
    a_op(0, 8'h20, 0, 4'hF);
    sample(); check("t3_rd_wait", a_waitrequest, 0);
    push_a(32'hAAAA5678);
    next(); idle();
    b_op(1, 8'h02, 32'h22222222, 4'hF);
    sample(); check("t3_bw_wait", b_waitrequest, 0);
    next(); idle();
    repeat (3) next();

    // continuous conflict alternates, A first
    a_op(0, 8'h01, 0, 4'hF);
    b_op(0, 8'h02, 0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i % 2 == 0) begin
        check("t2_a_wait", a_waitrequest, 0);
        check("t2_b_wait", b_waitrequest, 1);
        push_a(32'h11111111);
      end else begin
        check("t2_a_wait", a_waitrequest, 1);
        check("t2_b_wait", b_waitrequest, 0);
        push_b(32'h22222222);
      end
      next();
    end
    idle();
    repeat (3) next();

    // lock, then idle timeout releases B after 16 cycles
    a_op(0, 8'h10, 0, 4'hF);
    a_lock = 1;
    sample(); check("t4_a_wait", a_waitrequest, 0);
    push_a(32'hDEADBEEF);
    next(); idle();
    b_op(0, 8'h02, 0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      sample(); check("t4_b_locked", b_waitrequest, 1);
      next();
    end
    sample(); check("t4_b_release", b_waitrequest, 0);
    push_b(32'h22222222);
    next(); idle();
    repeat (3) next();

    // lock overrides round-robin, A issue with lock low releases
    a_op(0, 8'h01, 0, 4'hF); a_lock = 1;
    b_op(0, 8'h02, 0, 4'hF);
    sample();
    check("t4b_a1_wait", a_waitrequest, 0);
    check("t4b_b1_wait", b_waitrequest, 1);
    push_a(32'h11111111);
    next();
    a_op(0, 8'h10, 0, 4'hF); a_lock = 0;
    sample();
    check("t4b_a2_wait", a_waitrequest, 0);
    check("t4b_b2_wait", b_waitrequest, 1);
    push_a(32'hDEADBEEF);
    next();
    a_read = 0;
    sample(); check("t4b_b3_wait", b_waitrequest, 0);
    push_b(32'h22222222);
    next(); idle();
    repeat (3) next();

    // freeze with one read in flight
    a_op(0, 8'h01, 0, 4'hF);
    sample(); check("t5_pre_wait", a_waitrequest, 0);
    push_a(32'h11111111);
    next();
    reset_req = 1;
    a_op(0, 8'h10, 0, 4'hF);
    b_op(1, 8'h30, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t5_a_wait", a_waitrequest, 1);
      check("t5_b_wait", b_waitrequest, 1);
      check("t5_wren", ram_wren, 0);
      check("t5_rreq", ram_reset_req, 1);
      next();
    end
    reset_req = 0;
    b_write = 0;
    sample(); check("t5_resume", a_waitrequest, 0);
    push_a(32'hDEADBEEF);
    next(); idle();
    repeat (3) next();

    // reset kills an in-flight B read and restores last_grant
    b_op(0, 8'h02, 0, 4'hF);
    sample(); check("t6_b_wait", b_waitrequest, 0);
    next(); idle();
    reset_n = 0;
    sample(); chk_zero("t6");
    next();
    sample(); reset_n = 1;
    next();
    repeat (4) next();
    a_op(0, 8'h01, 0, 4'hF);
    b_op(0, 8'h02, 0, 4'hF);
    sample();
    check("t6_a_wins", a_waitrequest, 0);
    check("t6_b_loses", b_waitrequest, 1);
    push_a(32'h11111111);
    next(); idle();
    repeat (4) next();

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
